// File: rtl/fft_bank_reader_if.sv
// Bank read ports and result stream of the FFT bank reader.
// The master side is the reader; the slave side is the bank plus result consumer.
interface fft_bank_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] A_addr;
  logic [ADDR_W-1:0] B_addr;
  logic [DATA_W-1:0] A_dataOutR;
  logic [DATA_W-1:0] A_dataOutC;
  logic [DATA_W-1:0] B_dataOutR;
  logic [DATA_W-1:0] B_dataOutC;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_real;
  logic [DATA_W-1:0] out_imag;
  logic [ADDR_W-1:0] out_index;
  logic              out_last;

  modport master (
    output A_addr, B_addr, out_valid, out_real, out_imag, out_index, out_last,
    input  A_dataOutR, A_dataOutC, B_dataOutR, B_dataOutC, out_ready
  );

  modport slave (
    input  A_addr, B_addr, out_valid, out_real, out_imag, out_index, out_last,
    output A_dataOutR, A_dataOutC, B_dataOutR, B_dataOutC, out_ready
  );
endinterface

// File: rtl/fft_bank_reader.sv
// Drains the dual-port FFT sample bank two samples per read, optionally undoing
// bit-reversed storage, and streams them out through a 4-entry FIFO.
module fft_bank_reader #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 16,
  parameter int BIT_REVERSE = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  fft_bank_reader_if.master     bus,
  output logic                  busy,
  output logic                  done
);
  localparam int N     = 1 << ADDR_W;
  localparam int PAIRS = N / 2;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
    logic [ADDR_W-1:0] idx;
  } smp_t;

  function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] k);
    logic [ADDR_W-1:0] r;
    r = k;
    if (BIT_REVERSE != 0)
      for (int i = 0; i < ADDR_W; i++) r[i] = k[ADDR_W-1-i];
    return r;
  endfunction

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_p;
  logic              r_pend;
  logic [ADDR_W-1:0] r_a_addr, r_b_addr;
  smp_t              r_mem [4];
  logic [1:0]        r_wp, r_rp;
  logic [2:0]        r_cnt;
  logic              r_done;

  logic              w_issue;
  logic              w_pop;
  logic [ADDR_W-1:0] w_a_addr, w_b_addr;
  logic [ADDR_W-1:0] w_pm1;
  logic [ADDR_W-1:0] w_idx_a, w_idx_b;

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = READ;
      READ:    if (w_issue && r_p == ADDR_W'(PAIRS-1)) w_next = DRAIN;
      DRAIN:   if (r_cnt == 3'd0 && !r_pend) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Issue only when the FIFO is guaranteed room for the pair in flight plus this one.
  always_comb begin
    busy     = (r_state != IDLE);
    w_issue  = (r_state == READ) && ((r_cnt + {1'b0, r_pend, 1'b0}) <= 3'd2);
    w_a_addr = r_a_addr;
    w_b_addr = r_b_addr;
    if (r_state == IDLE) begin
      w_a_addr = '0;
      w_b_addr = '0;
    end else if (w_issue) begin
      w_a_addr = map_addr({r_p[ADDR_W-2:0], 1'b0});
      w_b_addr = map_addr({r_p[ADDR_W-2:0], 1'b1});
    end
  end

  assign w_pm1   = r_p - ADDR_W'(1);
  assign w_idx_a = {w_pm1[ADDR_W-2:0], 1'b0};
  assign w_idx_b = {w_pm1[ADDR_W-2:0], 1'b1};
  assign w_pop   = (r_cnt != 3'd0) && bus.out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_p      <= '0;
      r_pend   <= 1'b0;
      r_a_addr <= '0;
      r_b_addr <= '0;
      r_wp     <= '0;
      r_rp     <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      for (int i = 0; i < 4; i++) r_mem[i] <= '0;
    end else begin
      r_a_addr <= w_a_addr;
      r_b_addr <= w_b_addr;
      r_pend   <= w_issue;
      r_done   <= (r_state == DRAIN) && (w_next == IDLE);
      if (r_state == IDLE) r_p <= '0;
      else if (w_issue)    r_p <= r_p + ADDR_W'(1);
      // Bank data for the pair issued last cycle arrives now: A first, then B.
      if (r_pend) begin
        r_mem[r_wp]        <= '{re: bus.A_dataOutR, im: bus.A_dataOutC, idx: w_idx_a};
        r_mem[r_wp + 2'd1] <= '{re: bus.B_dataOutR, im: bus.B_dataOutC, idx: w_idx_b};
        r_wp               <= r_wp + 2'd2;
      end
      if (w_pop) r_rp <= r_rp + 2'd1;
      r_cnt <= r_cnt + (r_pend ? 3'd2 : 3'd0) - {2'b00, w_pop};
    end
  end

  assign bus.A_addr    = w_a_addr;
  assign bus.B_addr    = w_b_addr;
  assign bus.out_valid = (r_cnt != 3'd0);
  assign bus.out_real  = r_mem[r_rp].re;
  assign bus.out_imag  = r_mem[r_rp].im;
  assign bus.out_index = r_mem[r_rp].idx;
  assign bus.out_last  = (r_cnt != 3'd0) && (r_mem[r_rp].idx == ADDR_W'(N-1));
  assign done          = r_done;
endmodule
